// File: rtl/sum_window_accumulator.sv
// Accumulates a window of 1..15 samples from a valid/ready stream and holds the
// window's total, min, max, count and overflow flag until downstream takes it.
module sum_window_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  win_len,
  input  logic              flush,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [LEN_W-1:0]  out_cnt,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] mn;
  logic [DATA_W-1:0] mx;
  logic              ovf;

  logic              fire;
  logic              close;
  logic [LEN_W-1:0]  len_eff;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  acc_nxt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] mn_nxt;
  logic [DATA_W-1:0] mx_nxt;
  logic              ovf_nxt;

  assign fire = in_valid && in_ready;

  // The first sample of a window uses the live length, later ones the latched copy.
  assign len_eff = (cnt != '0)      ? len_q :
                   (win_len == '0)  ? LEN_W'(1) : win_len;

  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
  assign acc_nxt = fire ? sum_ext[ACC_W-1:0] : acc;
  assign ovf_nxt = ovf | (fire & sum_ext[ACC_W]);
  assign mn_nxt  = (fire && (in_data < mn)) ? in_data : mn;
  assign mx_nxt  = (fire && (in_data > mx)) ? in_data : mx;
  assign cnt_nxt = fire ? cnt + LEN_W'(1) : cnt;

  assign close = (state == ACC) &&
                 ((fire && (cnt_nxt == len_eff)) || (flush && ((cnt != '0) || fire)));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACC: begin
        in_ready = 1'b1;
        if (close) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      mn      <= '1;
      mx      <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_min <= '0;
      out_max <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (close) begin
      out_sum <= acc_nxt;
      out_min <= mn_nxt;
      out_max <= mx_nxt;
      out_cnt <= cnt_nxt;
      out_ovf <= ovf_nxt;
      acc     <= '0;
      cnt     <= '0;
      mn      <= '1;
      mx      <= '0;
      ovf     <= 1'b0;
    end else if (fire) begin
      if (cnt == '0) len_q <= len_eff;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      mn  <= mn_nxt;
      mx  <= mx_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule
